usb_rx_ctrl: RTL

USB full-speed receiver control stage. It sits directly downstream of eop_detect and the edge detector / NRZI decoder. It recovers bit timing from d_edge, deserialises decoded bits LSB-first, and checks the SYNC byte. It frames data bytes for the RX FIFO and validates packet termination using the eop signal from eop_detect.

---
 rtl/usb_rx_ctrl_if.sv | 33 +++
 rtl/usb_rx_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl_if - signal bundle between the USB FS line front end
// (edge detector, NRZI decoder, eop_detect), the receive control stage and
// the RX FIFO.
//   d_edge        single-cycle pulse on any D+ transition
//   eop           high while the line is in SE0
//   d_orig        NRZI-decoded, unstuffed bit
//   shift_enable  single-cycle bit-sample strobe
//   rx_data       last stored data byte
//   w_enable      single-cycle FIFO write strobe, rx_data valid alongside
//   receiving     high from packet start until return to idle
//   r_error       sticky packet error flag
// The slave modport is the receive controller; master is whatever drives
// the line-side inputs and consumes the results.
interface usb_rx_ctrl_if;
   logic       d_edge;
   logic       eop;
   logic       d_orig;
   logic       shift_enable;
   logic [7:0] rx_data;
   logic       w_enable;
   logic       receiving;
   logic       r_error;

   modport master (
      output d_edge, eop, d_orig,
      input  shift_enable, rx_data, w_enable, receiving, r_error
   );

   modport slave (
      input  d_edge, eop, d_orig,
      output shift_enable, rx_data, w_enable, receiving, r_error
   );
endinterface

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl - USB full-speed receive control stage.
// Recovers bit timing from d_edge, deserialises decoded bits LSB-first,
// checks the SYNC byte, frames data bytes for the RX FIFO and checks that
// the packet ends on a byte boundary.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   usb_rx_ctrl_if.slave (line inputs, FIFO write, status)
// Optional build macro: USB_RX_LEN_CHECK_EN - limits a packet to MAX_BYTES
// data bytes; an overlong packet is flagged in r_error and its extra bytes
// are not written. Without it MAX_BYTES is unused.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | bus idle, waiting for the first edge of a packet
// S_SYNC     | assembling the SYNC byte
// S_RECEIVE  | assembling data bytes, watching for SE0
// S_STORE    | one cycle: write completed byte to the FIFO
// S_EOP_WAIT | good EOP seen, waiting for the return to J
// S_ERR_EOP  | error seen, waiting for SE0
// S_ERR_IDLE | error seen and SE0 seen, waiting for the return to J
module usb_rx_ctrl #(
   parameter int         CLKS_PER_BIT = 8,
   parameter int         SAMPLE_PHASE = 3,
   parameter logic [7:0] SYNC_BYTE    = 8'h80,
   parameter int         MAX_BYTES    = 64
) (
   input logic          clk,
   input logic          rst,
   usb_rx_ctrl_if.slave bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PHASE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_RECEIVE,
      S_STORE,
      S_EOP_WAIT,
      S_ERR_EOP,
      S_ERR_IDLE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             byte_done_q, byte_done_d;
   logic [7:0]       rx_data_q;
   logic             w_enable_q;
   logic             receiving_q;
   logic             r_error_q;
   logic             strobe;
   logic             strobe_bit;
   logic             strobe_eop;
   logic             len_over;

   assign strobe     = (state_q != S_IDLE) && (clk_cnt_q == CNT_SAMPLE);
   // SE0 wins over a pending data bit at the sample point.
   assign strobe_bit = strobe && !bus.eop;
   assign strobe_eop = strobe && bus.eop;

   always_comb begin
      clk_cnt_d   = clk_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      byte_done_d = 1'b0;
      if (bus.d_edge || (state_q == S_IDLE) || (clk_cnt_q == CNT_LAST)) begin
         clk_cnt_d = '0;
      end else begin
         clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end
      // Bit count is realigned in idle so a packet aborted mid-byte cannot
      // skew the next SYNC.
      if (state_q == S_IDLE) begin
         bit_cnt_d = '0;
      end else if (strobe_bit) begin
         shreg_d     = {bus.d_orig, shreg_q[7:1]};
         bit_cnt_d   = bit_cnt_q + 3'd1;
         byte_done_d = (bit_cnt_q == 3'd7);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= 8'h00;
         byte_done_q <= 1'b0;
      end else begin
         clk_cnt_q   <= clk_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         byte_done_q <= byte_done_d;
      end
   end

`ifdef USB_RX_LEN_CHECK_EN
   localparam int BC_W = $clog2(MAX_BYTES + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BYTES);

   logic [BC_W-1:0] byte_cnt_q;

   assign len_over = (byte_cnt_q == BC_MAX);

   always_ff @(posedge clk) begin
      if (rst || (state_q == S_IDLE)) begin
         byte_cnt_q <= '0;
      end else if ((state_q == S_RECEIVE) && byte_done_q && !len_over) begin
         byte_cnt_q <= byte_cnt_q + BC_W'(1);
      end
   end
`else
   logic unused_max_bytes;

   assign len_over         = 1'b0;
   assign unused_max_bytes = ^MAX_BYTES;
`endif

   // Outputs are registered; w_enable/rx_data are loaded on entry to
   // S_STORE so they are valid during the S_STORE cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rx_data_q   <= 8'h00;
         w_enable_q  <= 1'b0;
         receiving_q <= 1'b0;
         r_error_q   <= 1'b0;
      end else begin
         w_enable_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.d_edge) begin
                  state_q     <= S_SYNC;
                  receiving_q <= 1'b1;
               end
            end
            S_SYNC: begin
               if (byte_done_q) begin
                  if (shreg_q == SYNC_BYTE) begin
                     state_q   <= S_RECEIVE;
                     r_error_q <= 1'b0;
                  end else begin
                     state_q   <= S_ERR_EOP;
                     r_error_q <= 1'b1;
                  end
               end else if (strobe_eop) begin
                  state_q   <= S_ERR_EOP;
                  r_error_q <= 1'b1;
               end
            end
            S_RECEIVE: begin
               if (byte_done_q) begin
                  if (len_over) begin
                     state_q   <= S_ERR_EOP;
                     r_error_q <= 1'b1;
                  end else begin
                     state_q    <= S_STORE;
                     rx_data_q  <= shreg_q;
                     w_enable_q <= 1'b1;
                  end
               end else if (strobe_eop) begin
                  if (bit_cnt_q == 3'd0) begin
                     state_q <= S_EOP_WAIT;
                  end else begin
                     state_q   <= S_ERR_IDLE;
                     r_error_q <= 1'b1;
                  end
               end
            end
            S_STORE: begin
               state_q <= S_RECEIVE;
            end
            S_EOP_WAIT: begin
               if (bus.d_edge) begin
                  state_q     <= S_IDLE;
                  receiving_q <= 1'b0;
               end
            end
            S_ERR_EOP: begin
               if (strobe_eop) begin
                  state_q <= S_ERR_IDLE;
               end
            end
            S_ERR_IDLE: begin
               if (bus.d_edge) begin
                  state_q     <= S_IDLE;
                  receiving_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               receiving_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.shift_enable = strobe;
   assign bus.rx_data      = rx_data_q;
   assign bus.w_enable     = w_enable_q;
   assign bus.receiving    = receiving_q;
   assign bus.r_error      = r_error_q;

endmodule
